// File: rtl/nonce_collector.sv
// Nonce collector: per-core found-edge capture, round-robin arbitration into a show-ahead FIFO.
// Optional NONCE_COLLECTOR_TIMESTAMP_EN adds a per-entry capture-cycle timestamp output.
module nonce_collector #(
  parameter int unsigned NUM_CORES = 8,
  parameter int unsigned DEPTH     = 4,
  localparam int unsigned CoreW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW     = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    clear,
  input  logic [NUM_CORES-1:0]    nonce_found_per_core,
  input  logic [NUM_CORES*32-1:0] nonce_per_core,
  input  logic                    pop,
  output logic                    rd_valid,
  output logic [31:0]             rd_nonce,
  output logic [CoreW-1:0]        rd_core,
  output logic [CntW-1:0]         count,
  output logic                    overflow
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
  ,
  output logic [31:0]             rd_timestamp
`endif
);

  logic [NUM_CORES-1:0] found_prev_q, pending_q, pending_d, edges;
  logic [31:0]          slot_nonce_q [NUM_CORES];
  logic [31:0]          mem_nonce_q  [DEPTH];
  logic [CoreW-1:0]     mem_core_q   [DEPTH];
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [CoreW-1:0]     rr_ptr_q, grant;
  logic [CoreW:0]       idx;
  logic                 overflow_q, grant_vld, push, push_ok, do_pop;

  assign edges   = nonce_found_per_core & ~found_prev_q;
  assign push_ok = (count_q != CntW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign push    = grant_vld && push_ok;
  assign count_d = count_q + CntW'(push) - CntW'(do_pop);

  // First pending core at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      idx = {1'b0, rr_ptr_q} + (CoreW+1)'(k);
      if (idx >= (CoreW+1)'(NUM_CORES)) idx = idx - (CoreW+1)'(NUM_CORES);
      if (!grant_vld && pending_q[idx[CoreW-1:0]]) begin
        grant_vld = 1'b1;
        grant     = idx[CoreW-1:0];
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (push) pending_d[grant] = 1'b0;
    pending_d = pending_d | (edges & ~pending_q);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      found_prev_q <= '0;
      pending_q    <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rr_ptr_q     <= '0;
      overflow_q   <= 1'b0;
    end else if (clear) begin
      // Held-high levels must not retrigger after a flush.
      found_prev_q <= nonce_found_per_core;
      pending_q    <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rr_ptr_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      found_prev_q <= nonce_found_per_core;
      pending_q    <= pending_d;
      count_q      <= count_d;
      if (|(edges & pending_q)) overflow_q <= 1'b1;
      if (push) begin
        wptr_q   <= wptr_q + 1'b1;
        rr_ptr_q <= (grant == CoreW'(NUM_CORES - 1)) ? '0 : grant + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) slot_nonce_q[i] <= '0;
    end else if (!clear) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (edges[i] && !pending_q[i]) slot_nonce_q[i] <= nonce_per_core[32*i +: 32];
      end
    end
  end

`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] slot_ts_q [NUM_CORES];
  logic [31:0] mem_ts_q  [DEPTH];

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      ts_q <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) slot_ts_q[i] <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (!clear) begin
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
          if (edges[i] && !pending_q[i]) slot_ts_q[i] <= ts_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_nonce_q[wptr_q] <= slot_nonce_q[grant];
      mem_core_q[wptr_q]  <= grant;
      mem_ts_q[wptr_q]    <= slot_ts_q[grant];
    end
  end

  assign rd_timestamp = rd_valid ? mem_ts_q[rptr_q] : '0;
`else
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_nonce_q[wptr_q] <= slot_nonce_q[grant];
      mem_core_q[wptr_q]  <= grant;
    end
  end
`endif

  // Gating keeps head data at zero while empty, including during reset.
  assign rd_valid = (count_q != '0);
  assign rd_nonce = rd_valid ? mem_nonce_q[rptr_q] : '0;
  assign rd_core  = rd_valid ? mem_core_q[rptr_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_nonce_collector.sv
// Scoreboard bench for nonce_collector: queue-based reference model, decoupled pop monitor.
`timescale 1ns/1ps
module tb_nonce_collector;
  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int CNTW  = 3;

  logic            clk = 1'b0;
  logic            arst = 1'b0;
  logic            clear = 1'b0;
  logic            pop = 1'b0;
  logic [N-1:0]    found = '0;
  logic [N*32-1:0] nonces = '0;
  logic            rd_valid, overflow;
  logic [31:0]     rd_nonce;
  logic [CW-1:0]   rd_core;
  logic [CNTW-1:0] count;
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
  logic [31:0]     rd_timestamp;
`endif

  nonce_collector #(.NUM_CORES(N), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .arst                 (arst),
    .clear                (clear),
    .nonce_found_per_core (found),
    .nonce_per_core       (nonces),
    .pop                  (pop),
    .rd_valid             (rd_valid),
    .rd_nonce             (rd_nonce),
    .rd_core              (rd_core),
    .count                (count),
    .overflow             (overflow)
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
    ,
    .rd_timestamp         (rd_timestamp)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0]   nonce;
    logic [CW-1:0] core;
  } entry_t;

  // Reference model: scoreboard queue of expected FIFO entries plus per-core bookkeeping.
  entry_t      sb_q[$];
  entry_t      mon_e;
  bit          m_prev[N];
  bit          m_pend[N];
  logic [31:0] m_held[N];
  int          m_count;
  int          m_rr;
  bit          m_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 1'b0;
      m_pend[i] = 1'b0;
      m_held[i] = '0;
    end
    m_count = 0;
    m_rr    = 0;
    m_ovf   = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_step();
    int start;
    int g;
    bit granted;
    bit was[N];
    entry_t e;
    if (clear) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = found[i];
      end
      m_count = 0;
      m_rr    = 0;
      m_ovf   = 1'b0;
      sb_q.delete();
      return;
    end
    start   = m_count;
    granted = 1'b0;
    g       = 0;
    for (int i = 0; i < N; i++) was[i] = m_pend[i];
    if (start < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        if (!granted && m_pend[(m_rr + k) % N]) begin
          granted = 1'b1;
          g       = (m_rr + k) % N;
        end
      end
    end
    if (granted) begin
      e.nonce = m_held[g];
      e.core  = CW'(g);
      sb_q.push_back(e);
      m_pend[g] = 1'b0;
      m_rr      = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (found[i] && !m_prev[i]) begin
        if (was[i]) m_ovf = 1'b1;
        else begin
          m_held[i] = nonces[32*i +: 32];
          m_pend[i] = 1'b1;
        end
      end
      m_prev[i] = found[i];
    end
    m_count = start + (granted ? 1 : 0) - ((pop && start > 0) ? 1 : 0);
  endtask

  task automatic check_state();
    check("count", 64'(count), 64'(m_count));
    check("rd_valid", 64'(rd_valid), 64'(m_count != 0));
    check("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic step(input logic [N-1:0] f, input bit p, input bit c);
    found = f;
    pop   = p;
    clear = c;
    model_step();
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic rand_nonces();
    for (int i = 0; i < N; i++) nonces[32*i +: 32] = $urandom();
  endtask

  // Monitor: every accepted pop must present the oldest expected entry.
  always @(negedge clk) begin
    if (arst && !clear && pop && rd_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty_model: got rd_valid=1 expected no entry at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("rd_nonce", 64'(rd_nonce), 64'(mon_e.nonce));
        check("rd_core", 64'(rd_core), 64'(mon_e.core));
      end
    end
  end

  logic [N-1:0] cur;

  initial begin
    // Reset state
    #12;
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_nonce", 64'(rd_nonce), 64'd0);
    model_reset();
    @(negedge clk);
    arst = 1'b1;

    // Single found on core 3
    step('0, 1'b0, 1'b0);
    rand_nonces();
    nonces[3*32 +: 32] = 32'h6000_1234;
    step(8'h08, 1'b0, 1'b0);
    step(8'h08, 1'b0, 1'b0);
    check("single_nonce", 64'(rd_nonce), 64'h6000_1234);
    check("single_core", 64'(rd_core), 64'd3);
    check("single_count", 64'(count), 64'd1);
    step(8'h08, 1'b1, 1'b0);
    check("single_popped", 64'(rd_valid), 64'd0);

    // Simultaneous edges on 0, 5, 7 from rr_ptr 0
    step('0, 1'b0, 1'b1);
    rand_nonces();
    step(8'hA1, 1'b0, 1'b0);
    repeat (3) step(8'hA1, 1'b0, 1'b0);
    check("simul_count", 64'(count), 64'd3);
    repeat (3) step(8'hA1, 1'b1, 1'b0);

    // Full FIFO holds core 2 pending without overflow
    step('0, 1'b0, 1'b1);
    rand_nonces();
    step(8'h1B, 1'b0, 1'b0);
    repeat (4) step(8'h1B, 1'b0, 1'b0);
    step(8'h1F, 1'b0, 1'b0);
    step(8'h1F, 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd4);
    check("full_ovf", 64'(overflow), 64'd0);
    step(8'h1F, 1'b1, 1'b0);
    step(8'h1F, 1'b0, 1'b0);
    check("full_refill", 64'(count), 64'd4);

    // Double edge on core 1 while still pending behind a full FIFO
    step(8'h1D, 1'b0, 1'b0);
    rand_nonces();
    step(8'h1F, 1'b0, 1'b0);
    step(8'h1D, 1'b0, 1'b0);
    rand_nonces();
    step(8'h1F, 1'b0, 1'b0);
    check("double_ovf", 64'(overflow), 64'd1);
    repeat (8) step(8'h1F, 1'b1, 1'b0);

    // Clear with count 3 and all levels held high
    step('0, 1'b0, 1'b0);
    rand_nonces();
    step(8'hFF, 1'b0, 1'b0);
    repeat (3) step(8'hFF, 1'b0, 1'b0);
    check("clr_pre_count", 64'(count), 64'd3);
    step(8'hFF, 1'b0, 1'b1);
    check("clr_count", 64'(count), 64'd0);
    check("clr_ovf", 64'(overflow), 64'd0);
    repeat (3) step(8'hFF, 1'b0, 1'b0);
    check("clr_quiet", 64'(count), 64'd0);

    // Asynchronous reset mid-push, then held-high levels captured once each
    step('0, 1'b0, 1'b0);
    rand_nonces();
    step(8'h3C, 1'b0, 1'b0);
    step(8'h3C, 1'b0, 1'b0);
    #3;
    arst = 1'b0;
    #1;
    check("arst_valid", 64'(rd_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_ovf", 64'(overflow), 64'd0);
    check("arst_nonce", 64'(rd_nonce), 64'd0);
    check("arst_core", 64'(rd_core), 64'd0);
    model_reset();
    found = 8'hC3;
    pop   = 1'b0;
    clear = 1'b0;
    rand_nonces();
    model_step();
    @(negedge clk);
    #2;
    arst = 1'b1;
    @(posedge clk);
    #1;
    check_state();
    repeat (6) step(8'hC3, 1'b0, 1'b0);
    check("arst_recap", 64'(count), 64'd4);
    repeat (6) step(8'hC3, 1'b1, 1'b0);

    // Randomized traffic
    cur = 8'hC3;
    repeat (1500) begin
      rand_nonces();
      for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) cur[i] = ~cur[i];
      step(cur, $urandom_range(2) == 0, $urandom_range(63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
